// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
// Round-robin arbiter letting two Avalon-MM masters (port 0 = CPU data master,
// port 1 = DMA/accelerator) share one single-port on-chip RAM. The grant is
// combinational in the request cycle. A master may hold a short lock for atomic
// sequences. Read data returns exactly one cycle after acceptance through the
// owning port's readdatavalid.
// Optional feature: define ONCHIP_MEM_ARB_PERF_EN to add the perf_clr input and
// the saturating stall counters perf_stall0/perf_stall1.

module onchip_mem_arbiter #(
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 32,
   parameter int BE_W     = 4,
   parameter int MAX_LOCK = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              hold,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic              m0_lock,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic              m1_lock,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata
`ifdef ONCHIP_MEM_ARB_PERF_EN
   ,
   input  logic              perf_clr,
   output logic [31:0]       perf_stall0,
   output logic [31:0]       perf_stall1
`endif
);

   localparam int LOCK_W = $clog2(MAX_LOCK + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              last_grant;
   logic              last_grant_next;
   logic [LOCK_W-1:0] lock_cnt;
   logic [LOCK_W-1:0] lock_cnt_next;
   logic [LOCK_W-1:0] lock_cnt_inc;
   logic              rd_pend;
   logic              rd_pend_next;
   logic              rd_owner;
   logic              rd_owner_next;

   logic              req0;
   logic              req1;
   logic              grant0;
   logic              grant1;
   logic              granted;
   logic              grant_sel;
   logic              sel_read;
   logic              sel_write;
   logic              sel_lock;
   logic              accept_read;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // Pick at most one port to serve this cycle: the lock owner only while a
   // tenure is open, otherwise whichever port asks, alternating on a tie.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset_n && !hold) begin
         case (state)
            OWN0: begin
               grant0 = req0;
            end
            OWN1: begin
               grant1 = req1;
            end
            default: begin
               if (req0 && req1) begin
                  grant0 = last_grant;
                  grant1 = ~last_grant;
               end else begin
                  grant0 = req0;
                  grant1 = req1;
               end
            end
         endcase
      end
   end

   assign granted   = grant0 | grant1;
   assign grant_sel = grant1;

   assign sel_read    = grant_sel ? m1_read  : m0_read;
   assign sel_write   = grant_sel ? m1_write : m0_write;
   assign sel_lock    = grant_sel ? m1_lock  : m0_lock;
   assign accept_read = granted & sel_read & ~sel_write;

   assign mem_chipselect = granted;
   assign mem_write      = granted & sel_write;
   assign mem_address    = grant_sel ? m1_address    : m0_address;
   assign mem_byteenable = grant_sel ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = grant_sel ? m1_writedata  : m0_writedata;

   assign m0_waitrequest = ~grant0;
   assign m1_waitrequest = ~grant1;

   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rd_pend & ~rd_owner;
   assign m1_readdatavalid = rd_pend &  rd_owner;

   // Next-state logic: open, extend or close a lock tenure on every accepted
   // transfer, and release an owner that goes quiet without holding its lock.
   // lock_cnt counts transfers already taken in the tenure, so lock_cnt_inc is
   // the count including the one being accepted now.
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      lock_cnt_next   = lock_cnt;
      lock_cnt_inc    = lock_cnt + 1'b1;
      rd_pend_next    = accept_read;
      rd_owner_next   = accept_read ? grant_sel : rd_owner;

      if (granted) begin
         last_grant_next = grant_sel;
         if (!sel_lock) begin
            state_next    = IDLE;
            lock_cnt_next = '0;
         end else if (lock_cnt_inc == LOCK_W'(MAX_LOCK)) begin
            state_next    = IDLE;
            lock_cnt_next = '0;
         end else begin
            state_next    = grant_sel ? OWN1 : OWN0;
            lock_cnt_next = lock_cnt_inc;
         end
      end else if (!hold) begin
         if (state == OWN0 && !req0 && !m0_lock) begin
            state_next    = IDLE;
            lock_cnt_next = '0;
         end else if (state == OWN1 && !req1 && !m1_lock) begin
            state_next    = IDLE;
            lock_cnt_next = '0;
         end
      end
   end

   // State register; reset forgets any read in flight and lets port 0 win the
   // first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         lock_cnt   <= '0;
         rd_pend    <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         lock_cnt   <= lock_cnt_next;
         rd_pend    <= rd_pend_next;
         rd_owner   <= rd_owner_next;
      end
   end

`ifndef SYNTHESIS
   // A master raising read and write together is a protocol error; the write
   // is served and the read dropped.
   a_m0_rw_exclusive : assert property (@(posedge clk) disable iff (!reset_n)
      !(m0_read && m0_write));
   a_m1_rw_exclusive : assert property (@(posedge clk) disable iff (!reset_n)
      !(m1_read && m1_write));
`endif

`ifdef ONCHIP_MEM_ARB_PERF_EN
   logic stall0;
   logic stall1;

   assign stall0 = req0 & m0_waitrequest;
   assign stall1 = req1 & m1_waitrequest;

   // Saturating stall counters; a clear request overrides a same-cycle count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall0 <= '0;
         perf_stall1 <= '0;
      end else if (perf_clr) begin
         perf_stall0 <= '0;
         perf_stall1 <= '0;
      end else begin
         if (stall0 && (perf_stall0 != 32'hFFFF_FFFF)) begin
            perf_stall0 <= perf_stall0 + 32'd1;
         end
         if (stall1 && (perf_stall1 != 32'hFFFF_FFFF)) begin
            perf_stall1 <= perf_stall1 + 32'd1;
         end
      end
   end
`endif

endmodule
